// File: rtl/motor_drive_sequencer.sv
// motor_drive_sequencer
// Command-level sequencer for the pwmc motor driver. Takes duty/direction/
// period commands over a valid/ready handshake and slews dutyCycle toward
// the target one STEP every RAMP_DIV clocks. A direction reversal runs
// decelerate -> brake dwell -> direction flip -> re-accelerate. A
// level-sensitive emergency stop overrides everything except reset.
module motor_drive_sequencer #(
  parameter int          RAMP_DIV       = 1000,
  parameter int          STEP           = 1,
  parameter int          BRAKE_CYCLES   = 50000,
  parameter logic [7:0]  PERIOD_DEFAULT = 8'd100
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_duty,
  input  logic       cmd_dir,
  input  logic [7:0] cmd_period,
  input  logic       estop,
  output logic [7:0] dutyCycle,
  output logic [7:0] period,
  output logic       direction,
  output logic       brake,
  output logic       pwmOutEnable,
  output logic       at_target,
  output logic       busy
);

  // One shared tick counter serves both the ramp divider and the brake dwell,
  // so it is sized for the larger of the two.
  localparam int CNT_MAX = (RAMP_DIV > BRAKE_CYCLES) ? RAMP_DIV : BRAKE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RAMP_LAST  = CNT_W'(RAMP_DIV - 1);
  localparam logic [CNT_W-1:0] BRAKE_LAST = CNT_W'(BRAKE_CYCLES - 1);
  localparam logic [7:0]       STEP_W     = 8'(STEP);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_DECEL = 3'd3,
    ST_BRAKE = 3'd4,
    ST_ESTOP = 3'd5
  } state_t;

  state_t           state_r;
  state_t           state_nxt;

  logic [7:0]       duty_r;
  logic [7:0]       duty_nxt;
  logic [7:0]       tgt_period_r;
  logic [7:0]       tgt_period_nxt;
  logic [7:0]       tgt_duty_r;
  logic [7:0]       tgt_duty_nxt;
  logic             tgt_dir_r;
  logic             tgt_dir_nxt;
  logic             dir_r;
  logic             dir_nxt;
  logic             brake_r;
  logic             brake_nxt;
  logic             en_r;
  logic             en_nxt;
  logic             at_target_r;
  logic             at_target_nxt;
  logic             busy_r;
  logic             busy_nxt;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt;

  logic             ready_s;
  logic             accept_s;
  logic             tick_s;
  logic [7:0]       clamp_duty_s;
  logic [7:0]       ramp_duty_s;

  // Move cur one STEP toward tgt, landing exactly on tgt instead of
  // overshooting it or wrapping past the 8-bit range.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt);
    logic [7:0] res;
    if (cur < tgt) begin
      if ((tgt - cur) > STEP_W) begin
        res = cur + STEP_W;
      end else begin
        res = tgt;
      end
    end else if (cur > tgt) begin
      if ((cur - tgt) > STEP_W) begin
        res = cur - STEP_W;
      end else begin
        res = tgt;
      end
    end else begin
      res = cur;
    end
    return res;
  endfunction

  // Handshake is the only combinational output: open in IDLE/HOLD only.
  assign ready_s      = ((state_r == ST_IDLE) || (state_r == ST_HOLD)) && !estop && !reset;
  assign accept_s     = cmd_valid && ready_s;
  assign tick_s       = (cnt_r == RAMP_LAST);
  assign clamp_duty_s = (cmd_duty > cmd_period) ? cmd_period : cmd_duty;

  assign cmd_ready    = ready_s;
  assign dutyCycle    = duty_r;
  assign period       = tgt_period_r;
  assign direction    = dir_r;
  assign brake        = brake_r;
  assign pwmOutEnable = en_r;
  assign at_target    = at_target_r;
  assign busy         = busy_r;

  // Next-state and next-output logic; estop outranks accept, accept outranks ramp ticks.
  always_comb begin
    state_nxt      = state_r;
    duty_nxt       = duty_r;
    tgt_period_nxt = tgt_period_r;
    tgt_duty_nxt   = tgt_duty_r;
    tgt_dir_nxt    = tgt_dir_r;
    dir_nxt        = dir_r;
    brake_nxt      = brake_r;
    en_nxt         = en_r;
    cnt_nxt        = cnt_r;
    ramp_duty_s    = duty_r;

    if (estop) begin
      state_nxt = ST_ESTOP;
      duty_nxt  = 8'd0;
      brake_nxt = 1'b1;
      en_nxt    = 1'b0;
      cnt_nxt   = '0;
    end else begin
      // Command capture is common to IDLE and HOLD; the per-state branches
      // below only decide where to go next.
      if (accept_s) begin
        tgt_period_nxt = cmd_period;
        tgt_dir_nxt    = cmd_dir;
        tgt_duty_nxt   = clamp_duty_s;
        cnt_nxt        = '0;
        if (duty_r > cmd_period) begin
          duty_nxt = cmd_period;
        end else begin
          duty_nxt = duty_r;
        end
      end else begin
        tgt_period_nxt = tgt_period_r;
      end

      case (state_r)
        ST_IDLE: begin
          en_nxt = 1'b0;
          if (accept_s) begin
            dir_nxt = cmd_dir;
            if (clamp_duty_s != 8'd0) begin
              en_nxt    = 1'b1;
              state_nxt = ST_RAMP;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            state_nxt = ST_IDLE;
          end
        end

        ST_HOLD: begin
          if (accept_s) begin
            if (cmd_dir == dir_r) begin
              state_nxt = ST_RAMP;
            end else begin
              state_nxt = ST_DECEL;
            end
          end else begin
            state_nxt = ST_HOLD;
          end
        end

        ST_RAMP: begin
          if (tick_s) begin
            ramp_duty_s = step_toward(duty_r, tgt_duty_r);
            cnt_nxt     = '0;
          end else begin
            ramp_duty_s = duty_r;
            cnt_nxt     = cnt_r + CNT_W'(1);
          end
          duty_nxt = ramp_duty_s;
          // Arrival is evaluated on the step result so the state change
          // lands on the same edge as the final step.
          if (ramp_duty_s == tgt_duty_r) begin
            cnt_nxt = '0;
            if (tgt_duty_r != 8'd0) begin
              state_nxt = ST_HOLD;
            end else begin
              state_nxt = ST_IDLE;
              en_nxt    = 1'b0;
            end
          end else begin
            state_nxt = ST_RAMP;
          end
        end

        ST_DECEL: begin
          if (tick_s) begin
            ramp_duty_s = step_toward(duty_r, 8'd0);
            cnt_nxt     = '0;
          end else begin
            ramp_duty_s = duty_r;
            cnt_nxt     = cnt_r + CNT_W'(1);
          end
          duty_nxt = ramp_duty_s;
          if (ramp_duty_s == 8'd0) begin
            brake_nxt = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_BRAKE;
          end else begin
            state_nxt = ST_DECEL;
          end
        end

        ST_BRAKE: begin
          brake_nxt = 1'b1;
          if (cnt_r == BRAKE_LAST) begin
            // Direction only flips once the motor has been held stopped.
            brake_nxt = 1'b0;
            dir_nxt   = tgt_dir_r;
            cnt_nxt   = '0;
            if (tgt_duty_r != 8'd0) begin
              state_nxt = ST_RAMP;
            end else begin
              state_nxt = ST_IDLE;
              en_nxt    = 1'b0;
            end
          end else begin
            cnt_nxt   = cnt_r + CNT_W'(1);
            state_nxt = ST_BRAKE;
          end
        end

        ST_ESTOP: begin
          // estop has dropped: release brake and forget the old target.
          brake_nxt    = 1'b0;
          tgt_duty_nxt = 8'd0;
          duty_nxt     = 8'd0;
          en_nxt       = 1'b0;
          cnt_nxt      = '0;
          state_nxt    = ST_IDLE;
        end

        default: begin
          state_nxt = ST_IDLE;
          duty_nxt  = 8'd0;
          brake_nxt = 1'b0;
          en_nxt    = 1'b0;
          cnt_nxt   = '0;
        end
      endcase
    end

    busy_nxt      = (state_nxt == ST_RAMP) || (state_nxt == ST_DECEL) || (state_nxt == ST_BRAKE);
    at_target_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_HOLD);
  end

  // State register and all registered outputs, with synchronous reset.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      duty_r       <= 8'd0;
      tgt_period_r <= PERIOD_DEFAULT;
      tgt_duty_r   <= 8'd0;
      tgt_dir_r    <= 1'b1;
      dir_r        <= 1'b1;
      brake_r      <= 1'b0;
      en_r         <= 1'b0;
      at_target_r  <= 1'b1;
      busy_r       <= 1'b0;
      cnt_r        <= '0;
    end else begin
      state_r      <= state_nxt;
      duty_r       <= duty_nxt;
      tgt_period_r <= tgt_period_nxt;
      tgt_duty_r   <= tgt_duty_nxt;
      tgt_dir_r    <= tgt_dir_nxt;
      dir_r        <= dir_nxt;
      brake_r      <= brake_nxt;
      en_r         <= en_nxt;
      at_target_r  <= at_target_nxt;
      busy_r       <= busy_nxt;
      cnt_r        <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// tb_motor_drive_sequencer
// Directed bench for motor_drive_sequencer with RAMP_DIV=4, STEP=1,
// BRAKE_CYCLES=10, PERIOD_DEFAULT=8. Inputs change and outputs are sampled
// 1 ns after the rising edge; expected values are hand-derived.
module tb_motor_drive_sequencer;

  logic       clk_50;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_duty;
  logic       cmd_dir;
  logic [7:0] cmd_period;
  logic       estop;
  logic [7:0] dutyCycle;
  logic [7:0] period;
  logic       direction;
  logic       brake;
  logic       pwmOutEnable;
  logic       at_target;
  logic       busy;

  int checks;
  int failures;

  motor_drive_sequencer #(
    .RAMP_DIV      (4),
    .STEP          (1),
    .BRAKE_CYCLES  (10),
    .PERIOD_DEFAULT(8'd8)
  ) dut (
    .clk_50      (clk_50),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_duty    (cmd_duty),
    .cmd_dir     (cmd_dir),
    .cmd_period  (cmd_period),
    .estop       (estop),
    .dutyCycle   (dutyCycle),
    .period      (period),
    .direction   (direction),
    .brake       (brake),
    .pwmOutEnable(pwmOutEnable),
    .at_target   (at_target),
    .busy        (busy)
  );

  // 50 MHz clock.
  initial begin
    clk_50 = 1'b0;
    forever #10 clk_50 = ~clk_50;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks = checks + 1;
    if (obs !== exp_v) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  // Present one command, confirm it is acceptable, and leave 1 ns after the accept edge.
  task automatic send(input logic [7:0] d, input logic dr, input logic [7:0] p);
    cmd_duty   = d;
    cmd_dir    = dr;
    cmd_period = p;
    cmd_valid  = 1'b1;
    #1;
    check_val("accept_ready", 32'(cmd_ready), 32'd1);
    step(1);
    cmd_valid = 1'b0;
  endtask

  // Starting 1 ns after an accept/ramp start edge, follow a unit-step ramp
  // that moves every 4 clocks; ends 1 ns after the edge that reaches 'to'.
  task automatic expect_ramp(input int from, input int to);
    int cur;
    int nxt;
    cur = from;
    while (cur != to) begin
      nxt = (cur < to) ? cur + 1 : cur - 1;
      step(3);
      check_val("ramp_before_step", 32'(dutyCycle), cur);
      step(1);
      check_val("ramp_step", 32'(dutyCycle), nxt);
      cur = nxt;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_duty"},   32'(dutyCycle),    32'd0);
    check_val({tag, "_period"}, 32'(period),       32'd8);
    check_val({tag, "_dir"},    32'(direction),    32'd1);
    check_val({tag, "_brake"},  32'(brake),        32'd0);
    check_val({tag, "_en"},     32'(pwmOutEnable), 32'd0);
    check_val({tag, "_at_tgt"}, 32'(at_target),    32'd1);
    check_val({tag, "_busy"},   32'(busy),         32'd0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_duty   = 8'd0;
    cmd_dir    = 1'b1;
    cmd_period = 8'd8;
    estop      = 1'b0;

    // Reset state.
    step(2);
    check_reset_values("rst");
    check_val("rst_ready_low", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    #1;
    check_val("rst_ready_after", 32'(cmd_ready), 32'd1);

    // 1. Ramp up 0 -> 5.
    send(8'd5, 1'b1, 8'd8);
    check_val("t1_en",     32'(pwmOutEnable), 32'd1);
    check_val("t1_dir",    32'(direction),    32'd1);
    check_val("t1_busy",   32'(busy),         32'd1);
    check_val("t1_at_tgt", 32'(at_target),    32'd0);
    check_val("t1_ready",  32'(cmd_ready),    32'd0);
    check_val("t1_duty0",  32'(dutyCycle),    32'd0);
    expect_ramp(0, 5);
    check_val("t1_done_at_tgt", 32'(at_target), 32'd1);
    check_val("t1_done_busy",   32'(busy),      32'd0);
    check_val("t1_done_ready",  32'(cmd_ready), 32'd1);

    // 2. Clamp: duty 12 against period 8, then shrink period from HOLD.
    send(8'd12, 1'b1, 8'd8);
    expect_ramp(5, 8);
    check_val("t2_at_tgt", 32'(at_target), 32'd1);
    step(8);
    check_val("t2_hold_8", 32'(dutyCycle), 32'd8);
    send(8'd4, 1'b1, 8'd4);
    check_val("t2_clamp_duty",   32'(dutyCycle), 32'd4);
    check_val("t2_clamp_period", 32'(period),    32'd4);
    step(1);
    check_val("t2_clamp_at_tgt", 32'(at_target), 32'd1);
    check_val("t2_clamp_busy",   32'(busy),      32'd0);

    // 3. Reversal from HOLD at duty 5, dir 1 to duty 3, dir 0.
    send(8'd5, 1'b1, 8'd8);
    expect_ramp(4, 5);
    check_val("t3_hold5", 32'(at_target), 32'd1);
    send(8'd3, 1'b0, 8'd8);
    check_val("t3_acc_dir",    32'(direction), 32'd1);
    check_val("t3_acc_at_tgt", 32'(at_target), 32'd0);
    expect_ramp(5, 0);
    check_val("t3_decel_dir",  32'(direction),    32'd1);
    check_val("t3_brake_on",   32'(brake),        32'd1);
    check_val("t3_brake_en",   32'(pwmOutEnable), 32'd1);
    step(9);
    check_val("t3_brake_last", 32'(brake),     32'd1);
    check_val("t3_dir_held",   32'(direction), 32'd1);
    step(1);
    check_val("t3_brake_off",  32'(brake),        32'd0);
    check_val("t3_dir_flip",   32'(direction),    32'd0);
    check_val("t3_en_kept",    32'(pwmOutEnable), 32'd1);
    expect_ramp(0, 3);
    check_val("t3_at_tgt", 32'(at_target), 32'd1);

    // 5. Stop to idle from HOLD at duty 2.
    send(8'd2, 1'b0, 8'd8);
    expect_ramp(3, 2);
    send(8'd0, 1'b0, 8'd8);
    expect_ramp(2, 0);
    check_val("t5_en",     32'(pwmOutEnable), 32'd0);
    check_val("t5_at_tgt", 32'(at_target),    32'd1);
    check_val("t5_busy",   32'(busy),         32'd0);
    check_val("t5_ready",  32'(cmd_ready),    32'd1);

    // 4. E-stop mid-ramp at duty 3, colliding with a command.
    send(8'd6, 1'b1, 8'd8);
    check_val("t4_dir", 32'(direction), 32'd1);
    expect_ramp(0, 3);
    estop      = 1'b1;
    cmd_duty   = 8'd7;
    cmd_dir    = 1'b0;
    cmd_period = 8'd7;
    cmd_valid  = 1'b1;
    #1;
    check_val("t4_ready_low", 32'(cmd_ready), 32'd0);
    step(1);
    check_val("t4_duty",   32'(dutyCycle),    32'd0);
    check_val("t4_brake",  32'(brake),        32'd1);
    check_val("t4_en",     32'(pwmOutEnable), 32'd0);
    check_val("t4_busy",   32'(busy),         32'd0);
    check_val("t4_at_tgt", 32'(at_target),    32'd0);
    check_val("t4_period_unchanged", 32'(period), 32'd8);
    check_val("t4_dir_unchanged",    32'(direction), 32'd1);
    step(2);
    check_val("t4_held_brake", 32'(brake),     32'd1);
    check_val("t4_held_ready", 32'(cmd_ready), 32'd0);
    estop     = 1'b0;
    cmd_valid = 1'b0;
    step(1);
    check_val("t4_rel_brake",  32'(brake),        32'd0);
    check_val("t4_rel_ready",  32'(cmd_ready),    32'd1);
    check_val("t4_rel_at_tgt", 32'(at_target),    32'd1);
    check_val("t4_rel_en",     32'(pwmOutEnable), 32'd0);
    check_val("t4_rel_duty",   32'(dutyCycle),    32'd0);

    // 6. Reset during BRAKE.
    send(8'd2, 1'b0, 8'd6);
    check_val("t6_dir0",    32'(direction), 32'd0);
    check_val("t6_period6", 32'(period),    32'd6);
    expect_ramp(0, 2);
    send(8'd2, 1'b1, 8'd6);
    expect_ramp(2, 0);
    check_val("t6_brake_on", 32'(brake), 32'd1);
    step(3);
    reset = 1'b1;
    step(1);
    check_reset_values("t6_rst");
    check_val("t6_rst_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    #1;
    check_val("t6_ready_after", 32'(cmd_ready), 32'd1);
    step(12);
    check_val("t6_idle_brake", 32'(brake),     32'd0);
    check_val("t6_idle_duty",  32'(dutyCycle), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
